// File: rtl/ctrl_pipe_decoder_if.sv
// Handshake bundle for ctrl_pipe_decoder.
// master drives instructions/controls, slave is the decoder.
interface ctrl_pipe_decoder_if #(
  parameter int REG_W = 5
) ();
  logic             valid_i;
  logic [6:0]       opcode_i;
  logic [REG_W-1:0] rd_i;
  logic [REG_W-1:0] rs1_i;
  logic [REG_W-1:0] rs2_i;
  logic             stall_i;
  logic             flush_i;
  logic             ready_o;
  logic             hazard_o;
  logic             illegal_o;
  logic             valid_o;
  logic             aluSrc_o;
  logic             memtoReg_o;
  logic             regWrite_o;
  logic             memRead_o;
  logic             memWrite_o;
  logic             branch_o;
  logic             jump_o;
  logic [2:0]       ALUOp_o;

  modport master (
    output valid_i, opcode_i, rd_i, rs1_i, rs2_i,
    output stall_i, flush_i,
    input  ready_o, hazard_o, illegal_o, valid_o,
    input  aluSrc_o, memtoReg_o, regWrite_o,
    input  memRead_o, memWrite_o, branch_o,
    input  jump_o, ALUOp_o
  );

  modport slave (
    input  valid_i, opcode_i, rd_i, rs1_i, rs2_i,
    input  stall_i, flush_i,
    output ready_o, hazard_o, illegal_o, valid_o,
    output aluSrc_o, memtoReg_o, regWrite_o,
    output memRead_o, memWrite_o, branch_o,
    output jump_o, ALUOp_o
  );
endinterface

// File: rtl/ctrl_pipe_decoder.sv
// RV32I control decoder with DEPTH-stage control pipe.
// Define CTRL_HAZARD_EN to build load-use bubble insertion.
module ctrl_pipe_decoder #(
  parameter int DEPTH = 3,
  parameter int REG_W = 5
) (
  input logic             clk_i,
  input logic             rst_ni,
  ctrl_pipe_decoder_if.slave bus
);
  localparam logic [6:0] OP_IMM = 7'b0010011;
  localparam logic [6:0] OP_R   = 7'b0110011;
  localparam logic [6:0] OP_BR  = 7'b1100011;
  localparam logic [6:0] OP_LD  = 7'b0000011;
  localparam logic [6:0] OP_ST  = 7'b0100011;
  localparam logic [6:0] OP_LUI = 7'b0110111;
  localparam logic [6:0] OP_AUI = 7'b0010111;
  localparam logic [6:0] OP_JAL = 7'b1101111;
  localparam logic [6:0] OP_JLR = 7'b1100111;

  typedef struct packed {
    logic             valid;
    logic [9:0]       word;
`ifdef CTRL_HAZARD_EN
    logic [REG_W-1:0] rd;
    logic             isLoad;
`endif
  } stage_t;

  stage_t     stg [DEPTH];
  stage_t     entry;
  stage_t     last;
  logic [9:0] word;
  logic [9:0] outWord;
  logic       legal;
  logic       hazard;
  logic       ready;

  // Opcode to {aluSrc,memtoReg,regWrite,memRead,memWrite,branch,jump,ALUOp}
  always_comb begin
    word  = '0;
    legal = 1'b1;
    unique case (1'b1)
      (bus.opcode_i == OP_IMM): word = 10'b1010000011;
      (bus.opcode_i == OP_R):   word = 10'b0010000010;
      (bus.opcode_i == OP_BR):  word = 10'b0000010001;
      (bus.opcode_i == OP_LD):  word = 10'b1111000000;
      (bus.opcode_i == OP_ST):  word = 10'b1000100000;
      (bus.opcode_i == OP_LUI): word = 10'b1010000100;
      (bus.opcode_i == OP_AUI): word = 10'b1010000101;
      (bus.opcode_i == OP_JAL): word = 10'b0010001110;
      (bus.opcode_i == OP_JLR): word = 10'b1010001110;
      default:                  legal = 1'b0;
    endcase
  end

`ifdef CTRL_HAZARD_EN
  logic usesRs1;
  logic usesRs2;
  logic rdHit;

  assign usesRs1 = bus.opcode_i inside
    {OP_IMM, OP_R, OP_BR, OP_LD, OP_ST, OP_JLR};
  assign usesRs2 = bus.opcode_i inside
    {OP_R, OP_BR, OP_ST};
  assign rdHit =
    ((stg[0].rd == bus.rs1_i) && usesRs1) ||
    ((stg[0].rd == bus.rs2_i) && usesRs2);
  assign hazard = ~bus.flush_i & bus.valid_i &
    stg[0].valid & stg[0].isLoad &
    (stg[0].rd != '0) & rdHit;
`else
  logic unusedRegs;

  assign unusedRegs = ^{bus.rd_i, bus.rs1_i, bus.rs2_i};
  assign hazard = 1'b0;
`endif

  assign ready = ~bus.stall_i & ~hazard & ~bus.flush_i;

  // Illegal or absent instructions enter stage 0 as bubbles
  always_comb begin
    entry = '0;
    if (bus.valid_i && legal) begin
      entry.valid = 1'b1;
      entry.word  = word;
`ifdef CTRL_HAZARD_EN
      entry.rd     = bus.rd_i;
      entry.isLoad = (bus.opcode_i == OP_LD);
`endif
    end
  end

  // Flush beats stall; stall freezes every stage
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      for (int k = 0; k < DEPTH; k++) stg[k] <= '0;
    end else if (bus.flush_i) begin
      for (int k = 0; k < DEPTH; k++) stg[k] <= '0;
    end else if (!bus.stall_i) begin
      stg[0] <= ready ? entry : '0;
      for (int k = 1; k < DEPTH; k++) stg[k] <= stg[k-1];
    end
  end

  assign last    = stg[DEPTH-1];
  assign outWord = last.valid ? last.word : '0;

  assign bus.ready_o   = ready;
  assign bus.hazard_o  = hazard;
  assign bus.illegal_o = bus.valid_i & ~legal;
  assign bus.valid_o   = last.valid;
  assign {bus.aluSrc_o, bus.memtoReg_o, bus.regWrite_o,
          bus.memRead_o, bus.memWrite_o, bus.branch_o,
          bus.jump_o, bus.ALUOp_o} = outWord;
endmodule

// File: tb/tb_ctrl_pipe_decoder.sv
// Directed table-driven bench for ctrl_pipe_decoder.
// Expectations follow CTRL_HAZARD_EN the same way as the design.
module tb_ctrl_pipe_decoder;
  localparam int DEPTH = 3;

  localparam logic [6:0] O_IMM = 7'b0010011;
  localparam logic [6:0] O_R   = 7'b0110011;
  localparam logic [6:0] O_BR  = 7'b1100011;
  localparam logic [6:0] O_LD  = 7'b0000011;
  localparam logic [6:0] O_ST  = 7'b0100011;
  localparam logic [6:0] O_LUI = 7'b0110111;
  localparam logic [6:0] O_AUI = 7'b0010111;
  localparam logic [6:0] O_JAL = 7'b1101111;
  localparam logic [6:0] O_JLR = 7'b1100111;
  localparam logic [6:0] O_BAD = 7'b1111111;

  localparam logic [9:0] W_IMM = 10'b1010000011;
  localparam logic [9:0] W_R   = 10'b0010000010;
  localparam logic [9:0] W_BR  = 10'b0000010001;
  localparam logic [9:0] W_LD  = 10'b1111000000;
  localparam logic [9:0] W_ST  = 10'b1000100000;
  localparam logic [9:0] W_LUI = 10'b1010000100;
  localparam logic [9:0] W_AUI = 10'b1010000101;
  localparam logic [9:0] W_JAL = 10'b0010001110;
  localparam logic [9:0] W_JLR = 10'b1010001110;
  localparam logic [9:0] W_0   = 10'b0;

  typedef struct {
    logic       v;
    logic [6:0] op;
    logic [4:0] rd;
    logic [4:0] rs1;
    logic [4:0] rs2;
    logic       st;
    logic       fl;
    logic       eRdy;
    logic       eHaz;
    logic       eIll;
    logic       eV;
    logic [9:0] eW;
  } vec_t;

  logic clk = 1'b0;
  logic rst_ni;
  int   tests = 0;
  int   fails = 0;
  vec_t vecs[$];

  ctrl_pipe_decoder_if #(.REG_W(5)) bus ();

  ctrl_pipe_decoder #(.DEPTH(DEPTH), .REG_W(5)) dut (
    .clk_i  (clk),
    .rst_ni (rst_ni),
    .bus    (bus)
  );

  always #5 clk = ~clk;

  function automatic logic [9:0] outWord();
    return {bus.aluSrc_o, bus.memtoReg_o, bus.regWrite_o,
            bus.memRead_o, bus.memWrite_o, bus.branch_o,
            bus.jump_o, bus.ALUOp_o};
  endfunction

  task automatic check(input string name,
                       input logic [13:0] got,
                       input logic [13:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s got=%b exp=%b (rdy,haz,ill,vld,word)",
               name, got, exp);
    end
  endtask

  task automatic add(input logic v, input logic [6:0] op,
                     input logic [4:0] rd, input logic [4:0] rs1,
                     input logic [4:0] rs2, input logic st,
                     input logic fl, input logic eRdy,
                     input logic eHaz, input logic eIll,
                     input logic eV, input logic [9:0] eW);
    vec_t r;
    r.v = v; r.op = op; r.rd = rd; r.rs1 = rs1; r.rs2 = rs2;
    r.st = st; r.fl = fl; r.eRdy = eRdy; r.eHaz = eHaz;
    r.eIll = eIll; r.eV = eV; r.eW = eW;
    vecs.push_back(r);
  endtask

  task automatic drive(input logic v, input logic [6:0] op);
    bus.valid_i  = v;
    bus.opcode_i = op;
    bus.rd_i     = 5'd7;
    bus.rs1_i    = 5'd0;
    bus.rs2_i    = 5'd0;
    bus.stall_i  = 1'b0;
    bus.flush_i  = 1'b0;
  endtask

  initial begin
    // row: v op rd rs1 rs2 st fl | rdy haz ill vld word
    // sweep, output lags acceptance by DEPTH cycles
    add(1, O_IMM, 7, 0, 0, 0, 0, 1, 0, 0, 0, W_0);
    add(1, O_R,   7, 0, 0, 0, 0, 1, 0, 0, 0, W_0);
    add(1, O_BR,  7, 0, 0, 0, 0, 1, 0, 0, 0, W_0);
    add(1, O_LD,  7, 0, 0, 0, 0, 1, 0, 0, 1, W_IMM);
    add(1, O_ST,  7, 0, 0, 0, 0, 1, 0, 0, 1, W_R);
    add(1, O_LUI, 7, 0, 0, 0, 0, 1, 0, 0, 1, W_BR);
    add(1, O_AUI, 7, 0, 0, 0, 0, 1, 0, 0, 1, W_LD);
    add(1, O_JAL, 7, 0, 0, 0, 0, 1, 0, 0, 1, W_ST);
    add(1, O_JLR, 7, 0, 0, 0, 0, 1, 0, 0, 1, W_LUI);
    add(1, O_BAD, 7, 0, 0, 0, 0, 1, 0, 1, 1, W_AUI);
    add(0, 7'd0,  7, 0, 0, 0, 0, 1, 0, 0, 1, W_JAL);
    add(0, 7'd0,  7, 0, 0, 0, 0, 1, 0, 0, 1, W_JLR);
    add(0, 7'd0,  7, 0, 0, 0, 0, 1, 0, 0, 0, W_0);
    // two-cycle stall with R at the output
    add(1, O_R,   7, 0, 0, 0, 0, 1, 0, 0, 0, W_0);
    add(1, O_LD,  7, 0, 0, 0, 0, 1, 0, 0, 0, W_0);
    add(1, O_IMM, 7, 0, 0, 0, 0, 1, 0, 0, 0, W_0);
    add(1, O_ST,  7, 0, 0, 1, 0, 0, 0, 0, 1, W_R);
    add(1, O_ST,  7, 0, 0, 1, 0, 0, 0, 0, 1, W_R);
    add(1, O_ST,  7, 0, 0, 0, 0, 1, 0, 0, 1, W_R);
    add(0, 7'd0,  7, 0, 0, 0, 0, 1, 0, 0, 1, W_LD);
    add(0, 7'd0,  7, 0, 0, 0, 0, 1, 0, 0, 1, W_IMM);
    add(0, 7'd0,  7, 0, 0, 0, 0, 1, 0, 0, 1, W_ST);
    // flush together with stall, 3 entries in flight
    add(1, O_BR,  7, 0, 0, 0, 0, 1, 0, 0, 0, W_0);
    add(1, O_LUI, 7, 0, 0, 0, 0, 1, 0, 0, 0, W_0);
    add(1, O_AUI, 7, 0, 0, 0, 0, 1, 0, 0, 0, W_0);
    add(1, O_JAL, 7, 0, 0, 1, 1, 0, 0, 0, 1, W_BR);
    add(1, O_IMM, 7, 0, 0, 0, 0, 1, 0, 0, 0, W_0);
    add(0, 7'd0,  7, 0, 0, 0, 0, 1, 0, 0, 0, W_0);
    add(0, 7'd0,  7, 0, 0, 0, 0, 1, 0, 0, 0, W_0);
    add(0, 7'd0,  7, 0, 0, 0, 0, 1, 0, 0, 1, W_IMM);
    add(0, 7'd0,  7, 0, 0, 0, 0, 1, 0, 0, 0, W_0);
`ifdef CTRL_HAZARD_EN
    // load rd=5 then R rs2=5: one bubble
    add(1, O_LD,  5, 0, 0, 0, 0, 1, 0, 0, 0, W_0);
    add(1, O_R,   6, 0, 5, 0, 0, 0, 1, 0, 0, W_0);
    add(1, O_R,   6, 0, 5, 0, 0, 1, 0, 0, 0, W_0);
    add(0, 7'd0,  7, 0, 0, 0, 0, 1, 0, 0, 1, W_LD);
    add(0, 7'd0,  7, 0, 0, 0, 0, 1, 0, 0, 0, W_0);
    add(0, 7'd0,  7, 0, 0, 0, 0, 1, 0, 0, 1, W_R);
    // load rd=0 never hazards
    add(1, O_LD,  0, 0, 0, 0, 0, 1, 0, 0, 0, W_0);
    add(1, O_R,   6, 0, 0, 0, 0, 1, 0, 0, 0, W_0);
    add(0, 7'd0,  7, 0, 0, 0, 0, 1, 0, 0, 0, W_0);
    add(0, 7'd0,  7, 0, 0, 0, 0, 1, 0, 0, 1, W_LD);
    add(0, 7'd0,  7, 0, 0, 0, 0, 1, 0, 0, 1, W_R);
`else
    // no detection: back-to-back, no bubble
    add(1, O_LD,  5, 0, 0, 0, 0, 1, 0, 0, 0, W_0);
    add(1, O_R,   6, 0, 5, 0, 0, 1, 0, 0, 0, W_0);
    add(0, 7'd0,  7, 0, 0, 0, 0, 1, 0, 0, 0, W_0);
    add(0, 7'd0,  7, 0, 0, 0, 0, 1, 0, 0, 1, W_LD);
    add(0, 7'd0,  7, 0, 0, 0, 0, 1, 0, 0, 1, W_R);
    add(0, 7'd0,  7, 0, 0, 0, 0, 1, 0, 0, 0, W_0);
`endif

    // reset held 3 cycles with R-type presented
    rst_ni = 1'b0;
    drive(1'b1, O_R);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk); #1;
      check($sformatf("reset%0d", i),
            {3'b0, bus.valid_o, outWord()}, 14'd0);
    end
    @(negedge clk);
    rst_ni = 1'b1;
    #1;
    for (int i = 0; i < DEPTH; i++) begin
      if (i > 0) begin
        @(negedge clk); #1;
      end
      check($sformatf("post_reset%0d", i),
            {3'b0, bus.valid_o, outWord()}, 14'd0);
    end
    @(negedge clk); #1;
    check("first_after_reset",
          {3'b0, bus.valid_o, outWord()}, {3'b0, 1'b1, W_R});

    repeat (DEPTH) begin
      @(negedge clk);
      drive(1'b0, 7'd0);
    end

    foreach (vecs[i]) begin
      @(negedge clk);
      bus.valid_i  = vecs[i].v;
      bus.opcode_i = vecs[i].op;
      bus.rd_i     = vecs[i].rd;
      bus.rs1_i    = vecs[i].rs1;
      bus.rs2_i    = vecs[i].rs2;
      bus.stall_i  = vecs[i].st;
      bus.flush_i  = vecs[i].fl;
      #1;
      check($sformatf("row%0d", i),
            {bus.ready_o, bus.hazard_o, bus.illegal_o,
             bus.valid_o, outWord()},
            {vecs[i].eRdy, vecs[i].eHaz, vecs[i].eIll,
             vecs[i].eV, vecs[i].eW});
    end

    @(negedge clk);
    drive(1'b0, 7'd0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
